// File: rtl/keccak_rc_gen.sv
// Keccak-f[1600] round-constant generator: sequences rounds on start/step and emits the
// compressed 8-bit iota constant. Define KECCAK_RC_ROM_EN to use a constant table instead of the LFSR.
module keccak_rc_gen #(
    parameter int unsigned NUM_ROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    output logic [7:0] rc,
    output logic [4:0] round_idx,
    output logic       busy,
    output logic       last,
    output logic       done
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

    state_t     state, state_nxt;
    logic [7:0] rc_nxt, rc_round;
    logic [4:0] idx_nxt, adv_idx;
    logic       done_nxt, advance, wrap;

    assign adv_idx = (state == IDLE) ? '0 : round_idx + 5'd1;

`ifdef KECCAK_RC_ROM_EN
    function automatic logic [7:0] rc_rom(input logic [4:0] r);
        case (r)
            5'd0:  rc_rom = 8'h01;
            5'd1:  rc_rom = 8'h32;
            5'd2:  rc_rom = 8'hBA;
            5'd3:  rc_rom = 8'hE0;
            5'd4:  rc_rom = 8'h3B;
            5'd5:  rc_rom = 8'h41;
            5'd6:  rc_rom = 8'hF1;
            5'd7:  rc_rom = 8'hA9;
            5'd8:  rc_rom = 8'h1A;
            5'd9:  rc_rom = 8'h18;
            5'd10: rc_rom = 8'h69;
            5'd11: rc_rom = 8'h4A;
            5'd12: rc_rom = 8'h7B;
            5'd13: rc_rom = 8'h9B;
            5'd14: rc_rom = 8'hB9;
            5'd15: rc_rom = 8'hA3;
            5'd16: rc_rom = 8'hA2;
            5'd17: rc_rom = 8'h90;
            5'd18: rc_rom = 8'h2A;
            5'd19: rc_rom = 8'hCA;
            5'd20: rc_rom = 8'hF1;
            5'd21: rc_rom = 8'hB0;
            5'd22: rc_rom = 8'h41;
            5'd23: rc_rom = 8'hE8;
            default: rc_rom = 8'h00;
        endcase
    endfunction

    assign rc_round = rc_rom(adv_idx);
`else
    logic [7:0] lfsr, lfsr_nxt, lfsr_adv;
    logic [6:0] ticks;

    // Seven LFSR ticks per round; tick j yields lane bit 2^j-1.
    always_comb begin
        lfsr_adv = lfsr;
        ticks    = '0;
        for (int unsigned j = 0; j < 7; j++) begin
            ticks[j] = lfsr_adv[0];
            lfsr_adv = {lfsr_adv[6:0], 1'b0} ^ (lfsr_adv[7] ? 8'h71 : 8'h00);
        end
    end

    assign rc_round = {ticks[6:2], 1'b0, ticks[1:0]};

    always_comb begin
        lfsr_nxt = lfsr;
        if (wrap)
            lfsr_nxt = 8'h01;
        else if (advance)
            lfsr_nxt = lfsr_adv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 8'h01;
        else
            lfsr <= lfsr_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        idx_nxt   = round_idx;
        done_nxt  = 1'b0;
        advance   = 1'b0;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    advance   = 1'b1;
                end
            end
            RUN: begin
                if (step) begin
                    if (round_idx == LAST_IDX)
                        wrap = 1'b1;
                    else
                        advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (advance) begin
            idx_nxt = adv_idx;
            rc_nxt  = rc_round;
        end
        if (wrap) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            rc_nxt    = '0;
            done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rc        <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rc        <= rc_nxt;
            round_idx <= idx_nxt;
            done      <= done_nxt;
        end
    end

    assign busy = (state == RUN);
    assign last = busy && (round_idx == LAST_IDX);

endmodule
